// File: rtl/ddc_seq_ctrl.sv
// Start-up / retune sequencer and config registers for the DDC chain.
// Holds the NCO tuning word, clears the filters, waits for settling, then gates output-valid.
//
// state  | meaning
// IDLE   | disabled; NCO and filters held in reset
// CLEAR  | filter state cleared for CLR_CYCLES clocks; NCO reset on first cycle
// SETTLE | counting output samples while the filters fill
// RUN    | output-valid gate open
module ddc_seq_ctrl #(
    parameter int W_FREQ     = 32,
    parameter int W_SETTLE   = 16,
    parameter int CLR_CYCLES = 8,
    parameter int SETTLE_RST = 64
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              cfg_wr,
    input  logic [1:0]        cfg_addr,
    input  logic [31:0]       cfg_wdata,
    input  logic              sample_stb,
    output logic [W_FREQ-1:0] nco_phase_inc,
    output logic              nco_phase_rst,
    output logic              dsp_clr,
    output logic              out_en,
    output logic              retune_done,
    output logic [1:0]        state,
    output logic [7:0]        retune_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CLEAR  = 2'd1,
        S_SETTLE = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [W_FREQ-1:0]   r_freq;
    logic [W_SETTLE-1:0] r_settle;
    logic [W_SETTLE-1:0] r_settle_cnt;
    logic [7:0]          r_clr_cnt;
    logic                r_enable;

    logic                w_wr_freq;
    logic                w_wr_settle;
    logic                w_wr_ctrl;
    logic                w_disable;
    logic                w_trig;
    logic                w_enter_clr;
    logic                w_enter_run;
    logic                w_clr_last;
    logic                w_settle_last;
    logic [W_FREQ-1:0]   w_freq_new;
    logic                w_unused;

    assign w_wr_freq     = cfg_wr & (cfg_addr == 2'd0);
    assign w_wr_settle   = cfg_wr & (cfg_addr == 2'd1);
    assign w_wr_ctrl     = cfg_wr & (cfg_addr == 2'd2);
    assign w_disable     = w_wr_ctrl & ~cfg_wdata[0];
    assign w_trig        = w_wr_freq | (w_wr_ctrl & cfg_wdata[1] & cfg_wdata[0]);
    assign w_freq_new    = w_wr_freq ? cfg_wdata[W_FREQ-1:0] : r_freq;
    assign w_clr_last    = (r_clr_cnt == 8'(CLR_CYCLES - 1));
    assign w_settle_last = sample_stb & (r_settle_cnt == W_SETTLE'(1));
    assign w_enter_run   = (w_state_nxt == S_RUN) & (r_state != S_RUN);
    assign w_unused      = ^cfg_wdata;
    assign state         = r_state;

    // Disable beats retune, retune beats normal progression.
    always_comb begin
        w_state_nxt = r_state;
        w_enter_clr = 1'b0;
        if (w_disable) begin
            w_state_nxt = S_IDLE;
        end else if (r_state == S_IDLE) begin
            if (w_wr_ctrl & cfg_wdata[0] & ~r_enable) begin
                w_state_nxt = S_CLEAR;
                w_enter_clr = 1'b1;
            end
        end else if (w_trig) begin
            w_state_nxt = S_CLEAR;
            w_enter_clr = 1'b1;
        end else begin
            case (r_state)
                S_CLEAR:  if (w_clr_last) w_state_nxt = (r_settle == '0) ? S_RUN : S_SETTLE;
                S_SETTLE: if (w_settle_last) w_state_nxt = S_RUN;
                default:  w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state       <= S_IDLE;
            r_freq        <= '0;
            r_settle      <= W_SETTLE'(SETTLE_RST);
            r_enable      <= 1'b0;
            r_clr_cnt     <= '0;
            r_settle_cnt  <= '0;
            nco_phase_inc <= '0;
            nco_phase_rst <= 1'b1;
            dsp_clr       <= 1'b1;
            out_en        <= 1'b0;
            retune_done   <= 1'b0;
            retune_cnt    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_wr_freq)   r_freq   <= cfg_wdata[W_FREQ-1:0];
            if (w_wr_settle) r_settle <= cfg_wdata[W_SETTLE-1:0];
            if (w_wr_ctrl)   r_enable <= cfg_wdata[0];

            if (w_enter_clr) begin
                r_clr_cnt     <= '0;
                nco_phase_inc <= w_freq_new;
            end else if (r_state == S_CLEAR) begin
                r_clr_cnt <= r_clr_cnt + 8'd1;
            end

            if (r_state == S_CLEAR && w_state_nxt == S_SETTLE)
                r_settle_cnt <= r_settle;
            else if (r_state == S_SETTLE && sample_stb && r_settle_cnt != '0)
                r_settle_cnt <= r_settle_cnt - W_SETTLE'(1);

            // Outputs are registered from the next state so they align with state.
            nco_phase_rst <= (w_state_nxt == S_IDLE) | w_enter_clr;
            dsp_clr       <= (w_state_nxt == S_IDLE) | (w_state_nxt == S_CLEAR);
            out_en        <= (w_state_nxt == S_RUN);
            retune_done   <= w_enter_run;
            if (w_enter_run && retune_cnt != 8'hFF)
                retune_cnt <= retune_cnt + 8'd1;
        end
    end

endmodule

// File: doc/ddc_seq_ctrl.md
Name: ddc_seq_ctrl

Overview:
- Sequencer and configuration controller for the 125 MHz DDC chain: complex mixer, cascaded CIC decimators and the 20 MHz FIR.
- Holds the NCO tuning word and sequences start-up and retune.
  - Clears the decimator state.
  - Waits for a programmable number of output samples while the filters settle.
  - Then enables output-valid gating.
- Sits between the host config bus and the DDC datapath, in the clk_125 domain.

Parameters:
- W_FREQ, 32, NCO phase-increment width.
- W_SETTLE, 16, settle-counter width.
- CLR_CYCLES, 8, clk cycles dsp_clr is held; must cover the longest pipeline depth. Legal range 1..255.
- SETTLE_RST, 64, reset value of the settle-count register.

Ports:
- clk, in, 1, DDC master clock (125 MHz).
- reset_b, in, 1, asynchronous active-low reset.
- cfg_wr, in, 1, config write strobe, one cycle per write.
- cfg_addr, in, 2, register address: 0 = FREQ, 1 = SETTLE, 2 = CTRL (bit0 enable, bit1 flush request, self-clearing), 3 = reserved (write ignored).
- cfg_wdata, in, 32, write data, LSB-aligned.
- sample_stb, in, 1, one-cycle pulse per output sample of the 20 MHz stage, synchronised to clk.
- nco_phase_inc, out, W_FREQ, applied NCO tuning word.
- nco_phase_rst, out, 1, NCO accumulator reset.
- dsp_clr, out, 1, synchronous clear for CIC/FIR state.
- out_en, out, 1, output-valid gate for sig_out.
- retune_done, out, 1, one-cycle pulse on entry to RUN.
- state, out, 2, 0 = IDLE, 1 = CLEAR, 2 = SETTLE, 3 = RUN.
- retune_cnt, out, 8, saturating count of RUN entries.

Behaviour:
- Reset values (all outputs registered):
  - state = IDLE, nco_phase_inc = 0, nco_phase_rst = 1, dsp_clr = 1.
  - out_en = 0, retune_done = 0, retune_cnt = 0.
  - Internal registers: freq_reg = 0, settle_reg = SETTLE_RST, enable = 0.
- Register writes:
  - Captured on the clk edge where cfg_wr = 1.
  - FREQ takes cfg_wdata[W_FREQ-1:0].
  - SETTLE takes cfg_wdata[W_SETTLE-1:0].
  - The flush bit is never stored.
  - Writes are accepted in every state; there is no busy signal.
- Retune trigger (trig): a write to FREQ, or a write to CTRL with bit1 = 1 while the written enable bit = 1.
- IDLE:
  - nco_phase_rst = 1, dsp_clr = 1, out_en = 0.
  - On the edge where enable becomes 1, go to CLEAR.
- CLEAR:
  - Entry: nco_phase_inc loads the newest FREQ value, using same-cycle write data if a write coincides; clear counter resets to 0.
  - dsp_clr = 1 throughout. nco_phase_rst = 1 during the first CLEAR cycle only. out_en = 0.
  - After CLR_CYCLES cycles in CLEAR:
    - settle_reg = 0: go straight to RUN.
    - otherwise: go to SETTLE.
- SETTLE:
  - dsp_clr = 0, nco_phase_rst = 0, out_en = 0.
  - The settle counter, loaded from settle_reg on entry, decrements on each sample_stb.
  - The strobe that takes the counter from 1 to 0 moves the FSM to RUN on that same edge.
  - settle_reg writes during SETTLE affect the next settle only.
- RUN:
  - out_en = 1.
  - retune_done pulses 1 on the first RUN cycle.
  - retune_cnt increments on RUN entry and saturates at 255.
- Priority, highest first:
  1. Disable (CTRL write with bit0 = 0) from any state: IDLE on that edge, out_en drops the next cycle.
  2. trig in CLEAR, SETTLE or RUN: re-enter CLEAR, restarting the clear count and reloading nco_phase_inc.
  3. Normal progression.
- Corner cases:
  - Enable plus FREQ in one write is impossible (different addresses).
  - A CTRL write with enable = 1 and flush = 1 from IDLE enters CLEAR once.
  - sample_stb outside SETTLE is ignored.
  - Async reset mid-operation forces the reset values immediately; the next enable starts from a full CLEAR.

Test Plan:
1. Reset, then write FREQ = 0x1999_999A and CTRL = 1.
   - CLEAR entered; nco_phase_inc = 0x1999_999A.
   - dsp_clr high exactly 8 cycles; nco_phase_rst high 1 cycle.
   - SETTLE ends after the 64th sample_stb (strobes every 6 clk).
   - Then out_en = 1, retune_done one pulse, retune_cnt = 1.
2. In RUN, write FREQ = 0x0800_0000.
   - Next cycle: state = CLEAR, out_en = 0, nco_phase_inc = 0x0800_0000.
   - RUN again after 8 + 64 strobes; retune_cnt = 2.
3. Write SETTLE = 0, then CTRL = 3 (flush).
   - CLEAR lasts 8 cycles, then RUN directly with no SETTLE cycle.
4. Disable mid-SETTLE (CTRL = 0 at strobe 30).
   - IDLE on that edge; dsp_clr = 1, out_en stays 0.
   - Re-enable: full CLEAR plus 64-strobe settle.
5. FREQ write on cycle 5 of CLEAR, and again coincident with the final settling strobe.
   - Both restart CLEAR with the new word.
   - No retune_done pulse until a settle completes uninterrupted.
6. Assert reset_b = 0 asynchronously in RUN, and force 300 retunes.
   - Reset: all outputs at reset values without a clk edge.
   - Retunes: retune_cnt saturates at 255.
